// File: rtl/peak_detect_ctrl.sv
// Peak-detect decimation controller: two samples per clock, per-window running
// max/min over DECIM sample pairs, one (max,min) result per window, NUM_WIN windows per capture.
module peak_detect_ctrl #(
    parameter int DW = 8,
    parameter int CW = 16,
    parameter int NW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [CW-1:0] decim,
    input  logic [NW-1:0] num_win,
    input  logic          in_valid,
    input  logic [DW-1:0] data1,
    input  logic [DW-1:0] data2,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_max,
    output logic [DW-1:0] out_min,
    output logic [NW-1:0] out_idx,
    output logic          busy,
    output logic          done,
    output logic          ovf
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t        r_state, w_next;
    logic          w_busy, w_done;

    logic          r_s1_valid;
    logic [DW-1:0] r_s1_max, r_s1_min;
    logic [CW-1:0] r_decim_m1, r_cnt;
    logic [NW-1:0] r_num_win, r_win;
    logic [DW-1:0] r_acc_max, r_acc_min;
    logic          r_out_valid, r_ovf;
    logic [DW-1:0] r_out_max, r_out_min;
    logic [NW-1:0] r_out_idx;

    logic          w_run, w_start_ok, w_step, w_first, w_final, w_last_win;
    logic          w_accept, w_load, w_drop;
    logic [DW-1:0] w_win_max, w_win_min;

    assign w_run      = (r_state == S_RUN);
    assign w_start_ok = (r_state == S_IDLE) && start && !abort;
    assign w_step     = w_run && r_s1_valid;
    assign w_first    = (r_cnt == '0);
    assign w_final    = w_step && (r_cnt == r_decim_m1);
    assign w_last_win = w_final && (r_win == r_num_win - NW'(1));
    assign w_accept   = r_out_valid && out_ready;
    // A completed window either lands in the output register or is dropped.
    assign w_load     = w_final && (!r_out_valid || out_ready);
    assign w_drop     = w_final && r_out_valid && !out_ready;
    assign w_win_max  = (w_first || (r_s1_max > r_acc_max)) ? r_s1_max : r_acc_max;
    assign w_win_min  = (w_first || (r_s1_min < r_acc_min)) ? r_s1_min : r_acc_min;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_busy = (r_state != S_IDLE);
        w_done = (r_state == S_DONE);
        if (abort) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (start) w_next = (num_win == '0) ? S_DONE : S_RUN;
                S_RUN:   if (w_last_win) w_next = S_DRAIN;
                S_DRAIN: if (!r_out_valid || out_ready) w_next = S_DONE;
                S_DONE:  w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_max    <= '0;
            r_s1_min    <= '0;
            r_decim_m1  <= '0;
            r_cnt       <= '0;
            r_num_win   <= '0;
            r_win       <= '0;
            r_acc_max   <= '0;
            r_acc_min   <= '0;
            r_out_valid <= 1'b0;
            r_out_max   <= '0;
            r_out_min   <= '0;
            r_out_idx   <= '0;
            r_ovf       <= 1'b0;
        end else if (abort) begin
            r_s1_valid  <= 1'b0;
            r_cnt       <= '0;
            r_win       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_s1_valid <= w_run && in_valid;
            if (w_run && in_valid) begin
                r_s1_max <= (data2 > data1) ? data2 : data1;
                r_s1_min <= (data2 < data1) ? data2 : data1;
            end

            if (w_start_ok) begin
                r_decim_m1 <= (decim == '0) ? '0 : decim - CW'(1);
                r_num_win  <= num_win;
                r_cnt      <= '0;
                r_win      <= '0;
                r_ovf      <= 1'b0;
            end

            if (w_step) begin
                r_acc_max <= w_win_max;
                r_acc_min <= w_win_min;
                if (w_final) begin
                    r_cnt <= '0;
                    r_win <= r_win + NW'(1);
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end

            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_max   <= w_win_max;
                r_out_min   <= w_win_min;
                r_out_idx   <= r_win;
            end else if (w_accept) begin
                r_out_valid <= 1'b0;
            end
            if (w_drop) r_ovf <= 1'b1;
        end
    end

    assign out_valid = r_out_valid;
    assign out_max   = r_out_max;
    assign out_min   = r_out_min;
    assign out_idx   = r_out_idx;
    assign busy      = w_busy;
    assign done      = w_done;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_peak_detect_ctrl.sv
// Bench for peak_detect_ctrl: window-level reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_peak_detect_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] decim = '0;
    logic [11:0] num_win = '0;
    logic        in_valid = 1'b0;
    logic [7:0]  data1 = '0;
    logic [7:0]  data2 = '0;
    logic        out_ready = 1'b1;
    logic        out_valid, busy, done, ovf;
    logic [7:0]  out_max, out_min;
    logic [11:0] out_idx;

    int errors = 0;
    int checks = 0;

    peak_detect_ctrl #(.DW(8), .CW(16), .NW(12)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .decim(decim), .num_win(num_win), .in_valid(in_valid),
        .data1(data1), .data2(data2), .out_valid(out_valid),
        .out_ready(out_ready), .out_max(out_max), .out_min(out_min),
        .out_idx(out_idx), .busy(busy), .done(done), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // Reference model: phase 0 idle, 1 run, 2 drain, 3 done.
    int          m_phase = 0;
    int          m_decim = 1;
    int          m_nwin  = 0;
    int          m_wcnt  = 0;
    logic        m_fv = 1'b0;
    logic [7:0]  m_fa = '0, m_fb = '0;
    logic [7:0]  m_samp[$];
    logic        m_ov = 1'b0;
    logic [7:0]  m_omax = '0, m_omin = '0;
    logic [11:0] m_oidx = '0;
    logic        m_ovf = 1'b0;

    task automatic model_step();
        int         ph;
        logic       old_ov, res, last;
        logic [7:0] mx, mn;
        int         ridx;
        ph = m_phase;
        old_ov = m_ov;
        res = 1'b0;
        last = 1'b0;
        mx = '0;
        mn = '1;
        ridx = 0;
        if (rst) begin
            m_phase = 0; m_decim = 1; m_nwin = 0; m_wcnt = 0; m_fv = 1'b0;
            m_samp.delete(); m_ov = 1'b0; m_omax = '0; m_omin = '0;
            m_oidx = '0; m_ovf = 1'b0;
        end else if (abort) begin
            m_phase = 0; m_fv = 1'b0; m_samp.delete(); m_wcnt = 0; m_ov = 1'b0;
        end else begin
            if (ph == 1 && m_fv) begin
                m_samp.push_back(m_fa);
                m_samp.push_back(m_fb);
                if (m_samp.size() == 2 * m_decim) begin
                    foreach (m_samp[i]) begin
                        if (m_samp[i] > mx) mx = m_samp[i];
                        if (m_samp[i] < mn) mn = m_samp[i];
                    end
                    res = 1'b1;
                    ridx = m_wcnt;
                    m_wcnt++;
                    last = (m_wcnt == m_nwin);
                    m_samp.delete();
                end
            end
            m_fv = (ph == 1) && in_valid;
            m_fa = data1;
            m_fb = data2;
            if (res) begin
                if (!old_ov || out_ready) begin
                    m_ov = 1'b1; m_omax = mx; m_omin = mn; m_oidx = 12'(ridx);
                end else begin
                    m_ovf = 1'b1;
                end
            end else if (old_ov && out_ready) begin
                m_ov = 1'b0;
            end
            case (ph)
                0: if (start) begin
                    m_decim = (decim == 0) ? 1 : int'(decim);
                    m_nwin  = int'(num_win);
                    m_ovf   = 1'b0;
                    m_wcnt  = 0;
                    m_samp.delete();
                    m_phase = (num_win == 0) ? 3 : 1;
                end
                1: if (res && last) m_phase = 2;
                2: if (!old_ov || out_ready) m_phase = 3;
                default: m_phase = 0;
            endcase
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    initial forever begin
        @(negedge clk);
        cmp("m_out_valid", 32'(out_valid), 32'(m_ov));
        cmp("m_out_max", 32'(out_max), 32'(m_omax));
        cmp("m_out_min", 32'(out_min), 32'(m_omin));
        cmp("m_out_idx", 32'(out_idx), 32'(m_oidx));
        cmp("m_busy", 32'(busy), 32'(m_phase != 0));
        cmp("m_done", 32'(done), 32'(m_phase == 3));
        cmp("m_ovf", 32'(ovf), 32'(m_ovf));
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pair(input logic [7:0] a, input logic [7:0] b);
        in_valid = 1'b1; data1 = a; data2 = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic go(input logic [15:0] d, input logic [11:0] n);
        decim = d; num_win = n; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 50) begin
            tick();
            n++;
        end
        cmp("wait_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tick(); tick();
        cmp("rst_out_valid", 32'(out_valid), 32'd0);
        cmp("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick();

        // 1: single window of four pairs
        go(16'd4, 12'd1);
        pair(8'd10, 8'd200); pair(8'd50, 8'd3); pair(8'd90, 8'd90); pair(8'd7, 8'd8);
        tick();
        cmp("t1_valid", 32'(out_valid), 32'd1);
        cmp("t1_max", 32'(out_max), 32'd200);
        cmp("t1_min", 32'(out_min), 32'd3);
        cmp("t1_idx", 32'(out_idx), 32'd0);
        tick();
        cmp("t1_done", 32'(done), 32'd1);
        tick();
        cmp("t1_busy", 32'(busy), 32'd0);

        // 2: three back-to-back windows of two pairs
        go(16'd2, 12'd3);
        pair(8'd1, 8'd2); pair(8'd3, 8'd4); pair(8'd5, 8'd6);
        pair(8'd7, 8'd8); pair(8'd9, 8'd10); pair(8'd11, 8'd12);
        tick();
        cmp("t2_idx", 32'(out_idx), 32'd2);
        cmp("t2_max", 32'(out_max), 32'd12);
        cmp("t2_min", 32'(out_min), 32'd9);
        tick();
        cmp("t2_done", 32'(done), 32'd1);
        wait_idle();

        // 3: backpressure drops two results
        out_ready = 1'b0;
        go(16'd1, 12'd4);
        pair(8'h11, 8'h22); pair(8'h99, 8'h01); pair(8'h55, 8'h66); pair(8'h33, 8'h44);
        cmp("t3_ovf", 32'(ovf), 32'd1);
        cmp("t3_hold_idx", 32'(out_idx), 32'd0);
        cmp("t3_hold_max", 32'(out_max), 32'h22);
        out_ready = 1'b1;
        tick();
        cmp("t3_idx", 32'(out_idx), 32'd3);
        cmp("t3_max", 32'(out_max), 32'h44);
        cmp("t3_min", 32'(out_min), 32'h33);
        wait_idle();

        // 4: decim 0 acts as 1, ties and extremes; then zero windows
        go(16'd0, 12'd2);
        cmp("t4_ovf_clr", 32'(ovf), 32'd0);
        pair(8'h80, 8'h80); pair(8'h00, 8'hFF);
        tick();
        cmp("t4_idx", 32'(out_idx), 32'd1);
        cmp("t4_max", 32'(out_max), 32'hFF);
        cmp("t4_min", 32'(out_min), 32'h00);
        wait_idle();
        go(16'd5, 12'd0);
        cmp("t4_zero_done", 32'(done), 32'd1);
        cmp("t4_zero_valid", 32'(out_valid), 32'd0);
        tick();
        cmp("t4_zero_busy", 32'(busy), 32'd0);

        // 5: abort mid-window, abort beats start, fresh restart
        go(16'd8, 12'd1);
        pair(8'd0, 8'd255); pair(8'd1, 8'd254); pair(8'd2, 8'd253);
        pair(8'd3, 8'd252); pair(8'd4, 8'd251);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        cmp("t5_busy", 32'(busy), 32'd0);
        cmp("t5_valid", 32'(out_valid), 32'd0);
        cmp("t5_done", 32'(done), 32'd0);
        start = 1'b1; abort = 1'b1; decim = 16'd2; num_win = 12'd1;
        tick();
        start = 1'b0; abort = 1'b0;
        cmp("t5_abort_wins", 32'(busy), 32'd0);
        go(16'd2, 12'd1);
        pair(8'd100, 8'd101); pair(8'd102, 8'd103);
        tick();
        cmp("t5_max", 32'(out_max), 32'd103);
        cmp("t5_min", 32'(out_min), 32'd100);
        wait_idle();

        // 6: reset while a result is pending, then gaps and a stray start
        go(16'd1, 12'd3);
        pair(8'h10, 8'h20);
        tick();
        cmp("t6_pre_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cmp("t6_rst_valid", 32'(out_valid), 32'd0);
        cmp("t6_rst_max", 32'(out_max), 32'd0);
        cmp("t6_rst_busy", 32'(busy), 32'd0);
        go(16'd2, 12'd2);
        pair(8'd5, 8'd9);
        tick();
        pair(8'd3, 8'd4);
        decim = 16'd7; num_win = 12'd1; start = 1'b1;
        pair(8'd200, 8'd100);
        start = 1'b0;
        tick();
        pair(8'd1, 8'd150);
        tick();
        cmp("t6_idx", 32'(out_idx), 32'd1);
        cmp("t6_max", 32'(out_max), 32'd200);
        cmp("t6_min", 32'(out_min), 32'd1);
        wait_idle();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
